// File: rtl/dac_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dac_tx_sequencer
// Purpose  : Serialises DAC sample words onto per-lane DDR bit pairs with a
//            training preamble, midscale underflow fill and a frame-marker
//            lane. Optional PRBS7 lane test mode: DAC_TX_PRBS_EN.
// Revision : 1.0
// ============================================================================
module dac_tx_sequencer #(
  parameter int LANES      = 4,
  parameter int DATA_W     = 8,
  parameter int SYNC_WORDS = 16
) (
  input  logic                    tx_clk,
  input  logic                    tx_rstn,
  input  logic                    tx_enable,
  input  logic                    tx_resync,
  input  logic [LANES*DATA_W-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [LANES-1:0]        tx_data_m,
  output logic [LANES-1:0]        tx_data_p,
  output logic                    tx_frame_m,
  output logic                    tx_frame_p,
  output logic [1:0]              tx_state,
  output logic                    tx_underflow,
  input  logic                    tx_underflow_clr
`ifdef DAC_TX_PRBS_EN
  ,
  input  logic                    tx_prbs_sel
`endif
);

  localparam int S    = DATA_W / 2;
  localparam int SCW  = (S > 1) ? $clog2(S) : 1;
  localparam int CNTW = $clog2(SYNC_WORDS + 1);
  localparam logic [SCW-1:0]    SC_LAST    = SCW'(S - 1);
  localparam logic [CNTW-1:0]   SYNC_LAST  = CNTW'(SYNC_WORDS - 1);
  localparam logic [DATA_W-1:0] TRAIN_WORD = {S{2'b10}};
  localparam logic [DATA_W-1:0] MIDSCALE   = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [SCW-1:0]                 sc_q, sc_d;
  logic [CNTW-1:0]                sync_cnt_q, sync_cnt_d;
  logic                           resync_pend_q, resync_pend_d;
  logic [LANES-1:0][DATA_W-1:0]   shift_q, shift_d;
  logic [LANES-1:0]               data_m_q, data_m_d;
  logic [LANES-1:0]               data_p_q, data_p_d;
  logic                           frame_q, frame_d;
  logic                           s_ready_q, s_ready_d;
  logic                           underflow_q, underflow_d;

  logic                           slot_end;
  logic                           load;
  logic                           accept;
  logic                           active_d;
  logic                           prbs_req;
  logic                           prbs_now;
  logic                           prbs_m;
  logic                           prbs_p;

  assign slot_end = (sc_q == SC_LAST);

  // Next state; mode changes only happen on slot boundaries.
  always_comb begin
    state_d       = state_q;
    sc_d          = sc_q;
    sync_cnt_d    = sync_cnt_q;
    resync_pend_d = resync_pend_q;
    load          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sc_d = '0;
        if (tx_enable) begin
          state_d    = ST_SYNC;
          sync_cnt_d = '0;
          load       = 1'b1;
        end
      end
      ST_SYNC: begin
        resync_pend_d = 1'b0;
        if (!slot_end) begin
          sc_d = sc_q + 1'b1;
        end else begin
          sc_d = '0;
          if (!tx_enable) begin
            state_d = ST_IDLE;
          end else if (sync_cnt_q == SYNC_LAST) begin
            state_d = ST_RUN;
            load    = 1'b1;
          end else begin
            sync_cnt_d = sync_cnt_q + 1'b1;
            load       = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!slot_end) begin
          sc_d          = sc_q + 1'b1;
          resync_pend_d = resync_pend_q | tx_resync;
        end else begin
          sc_d = '0;
          // A resync seen in the last cycle waits for the following slot,
          // keeping it consistent with the already-issued s_ready window.
          resync_pend_d = tx_resync;
          if (!tx_enable) begin
            state_d       = ST_IDLE;
            resync_pend_d = 1'b0;
          end else if (resync_pend_q) begin
            state_d       = ST_SYNC;
            sync_cnt_d    = '0;
            resync_pend_d = 1'b0;
            load          = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: begin
        state_d       = ST_IDLE;
        sc_d          = '0;
        resync_pend_d = 1'b0;
      end
    endcase
  end

`ifdef DAC_TX_PRBS_EN
  localparam logic [6:0] PRBS_SEED = 7'h7F;

  logic       prbs_sel_q, prbs_sel_d;
  logic       prbs_slot_q, prbs_slot_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic [6:0] lfsr_base, lfsr_mid, lfsr_two;

  always_comb begin
    prbs_req    = tx_prbs_sel;
    prbs_sel_d  = (sc_d == SC_LAST) ? tx_prbs_sel : prbs_sel_q;
    prbs_slot_d = load ? ((state_d == ST_RUN) && prbs_sel_q)
                       : (prbs_slot_q && (state_d == ST_RUN));
    prbs_now    = prbs_slot_d;
    lfsr_base   = (load && (state_d == ST_RUN) && (state_q == ST_SYNC)) ? PRBS_SEED : lfsr_q;
    lfsr_mid    = {lfsr_base[5:0], lfsr_base[6] ^ lfsr_base[5]};
    lfsr_two    = {lfsr_mid[5:0], lfsr_mid[6] ^ lfsr_mid[5]};
    prbs_m      = lfsr_mid[0];
    prbs_p      = lfsr_two[0];
    lfsr_d      = prbs_now ? lfsr_two : lfsr_base;
  end

  always_ff @(posedge tx_clk or negedge tx_rstn) begin
    if (!tx_rstn) begin
      prbs_sel_q  <= 1'b0;
      prbs_slot_q <= 1'b0;
      lfsr_q      <= PRBS_SEED;
    end else begin
      prbs_sel_q  <= prbs_sel_d;
      prbs_slot_q <= prbs_slot_d;
      lfsr_q      <= lfsr_d;
    end
  end
`else
  assign prbs_req = 1'b0;
  assign prbs_now = 1'b0;
  assign prbs_m   = 1'b0;
  assign prbs_p   = 1'b0;
`endif

  // Output stage: every output is computed for the next cycle and registered.
  always_comb begin
    logic [DATA_W-1:0] word;
    word     = '0;
    accept   = s_valid & s_ready_q;
    active_d = (state_d != ST_IDLE);
    data_m_d = '0;
    data_p_d = '0;
    shift_d  = '0;
    for (int n = 0; n < LANES; n++) begin
      if (state_d == ST_SYNC)  word = TRAIN_WORD;
      else if (accept)         word = s_data[n*DATA_W +: DATA_W];
      else                     word = MIDSCALE;
      if (active_d) begin
        if (load) begin
          data_m_d[n] = word[DATA_W-1];
          data_p_d[n] = word[DATA_W-2];
          shift_d[n]  = word << 2;
        end else begin
          data_m_d[n] = shift_q[n][DATA_W-1];
          data_p_d[n] = shift_q[n][DATA_W-2];
          shift_d[n]  = shift_q[n] << 2;
        end
        if (prbs_now) begin
          data_m_d[n] = prbs_m;
          data_p_d[n] = prbs_p;
        end
      end
    end
    frame_d     = active_d && (sc_d == '0);
    // The handshake window is decided one cycle ahead so s_ready is a flop.
    s_ready_d   = active_d && tx_enable && (sc_d == SC_LAST) && !resync_pend_d &&
                  !prbs_req && ((state_d == ST_RUN) || (sync_cnt_d == SYNC_LAST));
    underflow_d = (load && (state_d == ST_RUN) && !accept && !prbs_now) |
                  (underflow_q & ~tx_underflow_clr);
  end

  always_ff @(posedge tx_clk or negedge tx_rstn) begin
    if (!tx_rstn) begin
      state_q       <= ST_IDLE;
      sc_q          <= '0;
      sync_cnt_q    <= '0;
      resync_pend_q <= 1'b0;
      shift_q       <= '0;
      data_m_q      <= '0;
      data_p_q      <= '0;
      frame_q       <= 1'b0;
      s_ready_q     <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sc_q          <= sc_d;
      sync_cnt_q    <= sync_cnt_d;
      resync_pend_q <= resync_pend_d;
      shift_q       <= shift_d;
      data_m_q      <= data_m_d;
      data_p_q      <= data_p_d;
      frame_q       <= frame_d;
      s_ready_q     <= s_ready_d;
      underflow_q   <= underflow_d;
    end
  end

  assign tx_state     = state_q;
  assign tx_data_m    = data_m_q;
  assign tx_data_p    = data_p_q;
  assign tx_frame_m   = frame_q;
  assign tx_frame_p   = frame_q;
  assign s_ready      = s_ready_q;
  assign tx_underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_tx_sequencer
// Purpose  : Directed scoreboard bench for dac_tx_sequencer (2 lanes, 8-bit).
// Revision : 1.0
// ============================================================================
module tb_dac_tx_sequencer;

  localparam int LANES      = 2;
  localparam int DATA_W     = 8;
  localparam int SYNC_WORDS = 2;
  localparam int S          = DATA_W / 2;

  logic        tx_clk           = 1'b0;
  logic        tx_rstn          = 1'b0;
  logic        tx_enable        = 1'b0;
  logic        tx_resync        = 1'b0;
  logic        s_valid          = 1'b0;
  logic        tx_underflow_clr = 1'b0;
  logic [15:0] s_data           = '0;
  logic        s_ready, tx_frame_m, tx_frame_p, tx_underflow;
  logic [1:0]  tx_data_m, tx_data_p, tx_state;
`ifdef DAC_TX_PRBS_EN
  logic        tx_prbs_sel      = 1'b0;
  logic        prbs_h [0:127];
`endif

  typedef struct packed {
    logic [1:0] m;
    logic [1:0] p;
    logic       fm;
    logic       fp;
    logic [1:0] st;
    logic       rdy;
    logic       uf;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  dac_tx_sequencer #(
    .LANES      (LANES),
    .DATA_W     (DATA_W),
    .SYNC_WORDS (SYNC_WORDS)
  ) dut (
    .tx_clk           (tx_clk),
    .tx_rstn          (tx_rstn),
    .tx_enable        (tx_enable),
    .tx_resync        (tx_resync),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .tx_data_m        (tx_data_m),
    .tx_data_p        (tx_data_p),
    .tx_frame_m       (tx_frame_m),
    .tx_frame_p       (tx_frame_p),
    .tx_state         (tx_state),
    .tx_underflow     (tx_underflow),
    .tx_underflow_clr (tx_underflow_clr)
`ifdef DAC_TX_PRBS_EN
    , .tx_prbs_sel    (tx_prbs_sel)
`endif
  );

  always #5 tx_clk = ~tx_clk;

  function automatic obs_t observe();
    obs_t o;
    o.m   = tx_data_m;
    o.p   = tx_data_p;
    o.fm  = tx_frame_m;
    o.fp  = tx_frame_p;
    o.st  = tx_state;
    o.rdy = s_ready;
    o.uf  = tx_underflow;
    return o;
  endfunction

  task automatic push_rec(input logic [1:0] m, input logic [1:0] p, input logic fr,
                          input logic [1:0] st, input logic rdy, input logic uf);
    obs_t o;
    o.m = m; o.p = p; o.fm = fr; o.fp = fr; o.st = st; o.rdy = rdy; o.uf = uf;
    exp_q.push_back(o);
  endtask

  task automatic push_idle(input int len);
    for (int k = 0; k < len; k++) push_rec(2'b00, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  // w = {lane1, lane0}; each slot cycle k carries bits 7-2k / 6-2k of a lane.
  task automatic push_slot(input logic [15:0] w, input logic [1:0] st, input logic rdy_last,
                           input logic [3:0] ufv, input int len);
    logic [1:0] m, p;
    for (int k = 0; k < len; k++) begin
      for (int n = 0; n < LANES; n++) begin
        m[n] = w[n*8 + 7 - 2*k];
        p[n] = w[n*8 + 6 - 2*k];
      end
      push_rec(m, p, (k == 0), st, rdy_last && (k == S-1), ufv[k]);
    end
  endtask

`ifdef DAC_TX_PRBS_EN
  task automatic push_prbs(input int len);
    logic b0, b1;
    for (int k = 0; k < len; k++) begin
      b0 = prbs_h[7 + 2*k];
      b1 = prbs_h[8 + 2*k];
      push_rec({b0, b0}, {b1, b1}, (k % S == 0), 2'd2, 1'b0, 1'b0);
    end
  endtask
`endif

  task automatic check(input string tag, input obs_t e);
    obs_t o;
    o = observe();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge tx_clk);
      #1;
      cyc++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_underrun cyc=%0d observed=%h expected=none", cyc, observe());
      end else begin
        check("out", exp_q.pop_front());
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog cyc=%0d observed=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t zero_rec;
    zero_rec = '0;
`ifdef DAC_TX_PRBS_EN
    for (int i = 0; i < 7; i++) prbs_h[i] = 1'b1;
    for (int i = 7; i < 128; i++) prbs_h[i] = prbs_h[i-7] ^ prbs_h[i-6];
`endif

    // Reset held, then released with the link disabled.
    push_idle(3); run(3);
    tx_rstn = 1'b1;
    push_idle(1); run(1);

    // Link bring-up: two training words, handshake window in the last cycle.
    tx_enable = 1'b1;
    push_slot(16'hAAAA, 2'd1, 1'b0, 4'h0, 4);
    push_slot(16'hAAAA, 2'd1, 1'b1, 4'h0, 4);
    run(8);

    s_valid = 1'b1; s_data = 16'hC35A;
    push_slot(16'hC35A, 2'd2, 1'b1, 4'h0, 4);
    run(1);
    s_valid = 1'b0;
    run(3);

    // Missed window: midscale fill, sticky flag.
    push_slot(16'h8080, 2'd2, 1'b1, 4'hF, 4);
    run(4);

    // Clear coinciding with a new underflow keeps the flag; a lone clear drops it.
    tx_underflow_clr = 1'b1;
    push_slot(16'h8080, 2'd2, 1'b1, 4'b0011, 4);
    run(1);
    tx_underflow_clr = 1'b0;
    run(1);
    tx_underflow_clr = 1'b1;
    run(1);
    tx_underflow_clr = 1'b0;
    run(1);

    // Resync request during a data slot.
    s_valid = 1'b1; s_data = 16'h1E96;
    push_slot(16'h1E96, 2'd2, 1'b0, 4'h0, 4);
    run(1);
    s_valid = 1'b0; tx_resync = 1'b1;
    run(1);
    tx_resync = 1'b0;
    push_slot(16'hAAAA, 2'd1, 1'b0, 4'h0, 4);
    push_slot(16'hAAAA, 2'd1, 1'b1, 4'h0, 4);
    run(10);

    // Disable at sc=1: slot completes, then IDLE.
    s_valid = 1'b1; s_data = 16'h7EE1;
    push_slot(16'h7EE1, 2'd2, 1'b0, 4'h0, 4);
    run(1);
    s_valid = 1'b0;
    run(1);
    tx_enable = 1'b0;
    push_idle(2);
    run(4);

    // Re-enable, then reset mid-slot in RUN.
    tx_enable = 1'b1;
`ifdef DAC_TX_PRBS_EN
    tx_prbs_sel = 1'b1;
    push_slot(16'hAAAA, 2'd1, 1'b0, 4'h0, 4);
    push_slot(16'hAAAA, 2'd1, 1'b0, 4'h0, 4);
    push_prbs(2);
`else
    push_slot(16'hAAAA, 2'd1, 1'b0, 4'h0, 4);
    push_slot(16'hAAAA, 2'd1, 1'b1, 4'h0, 4);
    push_slot(16'h8080, 2'd2, 1'b0, 4'hF, 2);
`endif
    run(10);
    #1;
    tx_rstn = 1'b0;
    #1;
    check("async_reset", zero_rec);
    push_idle(2);
    run(2);
    tx_rstn = 1'b1;

`ifdef DAC_TX_PRBS_EN
    push_slot(16'hAAAA, 2'd1, 1'b0, 4'h0, 4);
    push_slot(16'hAAAA, 2'd1, 1'b0, 4'h0, 4);
    push_prbs(8);
`else
    push_slot(16'hAAAA, 2'd1, 1'b0, 4'h0, 4);
    push_slot(16'hAAAA, 2'd1, 1'b1, 4'h0, 4);
    push_slot(16'h8080, 2'd2, 1'b1, 4'hF, 4);
`endif
    run(exp_q.size());

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dac_tx_sequencer.md
# dac_tx_sequencer

Sequences parallel DAC sample words onto the per-lane DDR bit pairs (`tx_data_m`, `tx_data_p`) that feed the lane ODDR/OBUFDS output stage.

- Brings the link up with a training pattern, then streams samples.
- Substitutes midscale words on underflow.
- Drives a frame-marker lane.
- Sits in the `tx_clk` domain between the sample source and the LVDS output buffers.

## Interface
- `LANES`, 4, number of data lanes
- `DATA_W`, 8, bits per lane per sample; even, ≥4; slot length `S = DATA_W/2` clocks
- `SYNC_WORDS`, 16, training words sent before streaming, ≥1

Ports:
- `tx_clk`  in  1  sole clock
- `tx_rstn`  in  1  asynchronous active-low reset
- `tx_enable`  in  1  level; link enable
- `tx_resync`  in  1  pulse; request retraining while in RUN
- `s_data`  in  LANES*DATA_W  sample word; lane n = `s_data[n*DATA_W +: DATA_W]`
- `s_valid`  in  1  sample available
- `s_ready`  out  1  sample accepted when `s_valid & s_ready`
- `tx_data_m`  out  LANES  first bit of the clock (ODDR D1)
- `tx_data_p`  out  LANES  second bit of the clock (ODDR D2)
- `tx_frame_m`, `tx_frame_p`  out  1 each  frame-marker bit pair
- `tx_state`  out  2  0 = IDLE, 1 = SYNC, 2 = RUN
- `tx_underflow`  out  1  sticky underflow flag
- `tx_underflow_clr`  in  1  clears `tx_underflow`

## Operation
- All outputs are registered. Reset forces every output and all state to 0 immediately, including mid-slot.

Slot and shift register:
- Slot counter `sc` runs 0..S-1 in SYNC and RUN. It is held at 0 in IDLE.
- When `sc==0`, a lane-wide word is loaded into the shift register.
- In cycle k of the slot, each lane outputs `m = word[DATA_W-1-2k]` and `p = word[DATA_W-2-2k]`, i.e. MSB first.
- Frame lane is `m = p = 1` when `sc==0`, otherwise 0. It is 0 in IDLE.

States:
- **IDLE:** data and frame outputs are 0; `s_ready` is 0. `tx_enable=1` moves to SYNC on the next cycle, and the first SYNC slot starts there.
- **SYNC:** every lane sends the word `{S{2'b10}}` (m=1, p=0 every cycle). After `SYNC_WORDS` slots, moves to RUN at the slot boundary.
- **RUN:** each slot carries one accepted sample.
  - If no sample is accepted, the slot carries midscale `{1'b1, {DATA_W-1{1'b0}}}` on every lane, and `tx_underflow` is set.
  - `tx_resync` is latched as pending. At the next slot end it moves to SYNC with the training count reset.

Leaving the active states:
- `tx_enable=0` in SYNC or RUN takes effect only at slot end (`sc==S-1`): the current slot completes, then the next state is IDLE.
- Disable has priority over a pending resync.

`s_ready`:
- Asserted only when `sc==S-1` and the next state is RUN. This covers steady RUN and the final SYNC slot.
- It is a single-cycle window per slot.

Underflow flag:
- Set wins over clear when both occur in the same cycle.
- It is never set in SYNC or IDLE.

## Timing
- Latency: a word accepted at cycle t appears on the bit outputs at t+1 with k=0, and its last pair appears at t+S.
- Throughput: one sample per S clocks. No backpressure exists beyond the `s_ready` window.
- From `tx_enable` rising (sampled at t), the first SYNC bits appear at t+1. The first RUN bits appear at t+1+SYNC_WORDS*S.
- `tx_state` updates in the same cycle that the first bits of the new state appear.
- Frame marker and data are aligned to the same `tx_clk` cycle.

## Configuration
- Macro `DAC_TX_PRBS_EN`.
- **Defined:**
  - Adds input `tx_prbs_sel` (1 bit).
  - When it is 1 in RUN, `s_ready` stays 0 and no underflow is flagged.
  - All lanes carry PRBS7 (x^7+x^6+1), two bits per clock, m first.
  - The generator is seeded to 7'h7F on reset and on every entry to RUN.
  - `tx_prbs_sel` is sampled only at slot boundaries.
- **Undefined:** the port does not exist, no PRBS logic is built, and RUN always carries samples or midscale.

## Test plan
Bench configuration is LANES=2, DATA_W=8, SYNC_WORDS=2.
- **Reset:** pulse `tx_rstn` low mid-slot in RUN → all outputs 0 in that cycle and `tx_state=0`. After release with `tx_enable=1`, SYNC restarts.
- **Enable:** `tx_enable` 0→1 → 8 cycles of m=1/p=0 on both lanes; frame 1 in cycles 0 and 4; `s_ready=1` in cycle 7; `tx_state` goes 1 then 2 at cycle 8.
- **Data:** `s_data=16'hC35A` accepted → lane0 m/p = 0/1, 0/1, 1/0, 1/0 and lane1 = 1/1, 0/0, 0/0, 1/1, starting the cycle after acceptance.
- **Underflow:** `s_valid=0` at the `s_ready` cycle → both lanes 1/0, 0/0, 0/0, 0/0. `tx_underflow=1` the next cycle and holds until `tx_underflow_clr`. Clear and set in the same cycle → stays 1.
- **Disable/resync:** `tx_enable=0` at sc=1 → the slot finishes at sc=3, then outputs 0 and `tx_state=0`. `tx_resync` pulse in RUN → 2 SYNC words after the current slot, then RUN.
- **PRBS (DAC_TX_PRBS_EN):** `tx_prbs_sel=1` → first pairs after RUN entry follow PRBS7 from seed 7'h7F on both lanes; `s_ready` stays 0; `tx_underflow` stays 0.
